// File: rtl/irq_arbiter_pkg.sv
// Shared interrupt/cause encoding: exc_cause_e codes, mip/mie bit layout and FSM states.
// The fast-interrupt cause code is derived from the fast index by irq_fast_cause().
package irq_arbiter_pkg;

  localparam int IRQ_FAST_NUM = 15;
  localparam int IRQ_NUM      = 18;

  typedef enum logic [5:0] {
    EXC_CAUSE_NONE           = 6'h00,
    EXC_CAUSE_IRQ_SOFTWARE_M = 6'h23,
    EXC_CAUSE_IRQ_TIMER_M    = 6'h27,
    EXC_CAUSE_IRQ_EXTERNAL_M = 6'h2B,
    EXC_CAUSE_IRQ_FAST_0     = 6'h30,
    EXC_CAUSE_IRQ_FAST_1     = 6'h31,
    EXC_CAUSE_IRQ_FAST_2     = 6'h32,
    EXC_CAUSE_IRQ_FAST_3     = 6'h33,
    EXC_CAUSE_IRQ_FAST_4     = 6'h34,
    EXC_CAUSE_IRQ_FAST_5     = 6'h35,
    EXC_CAUSE_IRQ_FAST_6     = 6'h36,
    EXC_CAUSE_IRQ_FAST_7     = 6'h37,
    EXC_CAUSE_IRQ_FAST_8     = 6'h38,
    EXC_CAUSE_IRQ_FAST_9     = 6'h39,
    EXC_CAUSE_IRQ_FAST_10    = 6'h3A,
    EXC_CAUSE_IRQ_FAST_11    = 6'h3B,
    EXC_CAUSE_IRQ_FAST_12    = 6'h3C,
    EXC_CAUSE_IRQ_FAST_13    = 6'h3D,
    EXC_CAUSE_IRQ_FAST_14    = 6'h3E,
    EXC_CAUSE_IRQ_NM         = 6'h3F
  } exc_cause_e;

  // The 15 fast bits fill every position of the 18-bit vector not taken by MSI/MTI/MEI.
  localparam logic [4:0] CSR_MSIX_BIT = 5'd3;
  localparam logic [4:0] CSR_MTIX_BIT = 5'd7;
  localparam logic [4:0] CSR_MEIX_BIT = 5'd11;
  localparam logic [4:0] CSR_MFIX_BIT [IRQ_FAST_NUM] = '{
    5'd0,  5'd1,  5'd2,  5'd4,  5'd5,  5'd6,  5'd8,  5'd9,
    5'd10, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17
  };

  typedef logic [IRQ_NUM-1:0] irqs_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

  function automatic exc_cause_e irq_fast_cause(input logic [3:0] idx);
    return exc_cause_e'({1'b1, 5'd16 + {1'b0, idx}});
  endfunction

endpackage

// File: rtl/irq_arbiter_sync.sv
// N-bit, STAGES-deep flop synchronizer with asynchronous active-high reset.
// STAGES = 0 passes the input straight through.
module irq_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_flops
      logic [WIDTH-1:0] r_stage [STAGES];

      // Shift chain: stage 0 samples the asynchronous input.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int k = 0; k < int'(STAGES); k++) r_stage[k] <= '0;
        end else begin
          r_stage[0] <= i_d;
          for (int k = 1; k < int'(STAGES); k++) r_stage[k] <= r_stage[k-1];
        end
      end

      assign o_q = r_stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt source-side arbiter: synchronizes sources, holds mip pending state and
// presents the highest-priority eligible cause to the core on a req/ack handshake.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int unsigned             SYNC_STAGES = 2,
  parameter logic [IRQ_FAST_NUM-1:0] EDGE_FAST   = 15'h0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irqs_i,
  input  logic               irq_nm_i,
  input  logic [IRQ_NUM-1:0] csr_mie_i,
  input  logic               mstatus_mie_i,
  input  logic               debug_mode_i,
  output logic               irq_req_o,
  output logic [5:0]         irq_cause_o,
  input  logic               irq_ack_i,
  input  logic               nmi_done_i,
  output logic [IRQ_NUM-1:0] csr_mip_o
);

  logic [IRQ_NUM:0]   w_src, w_sync, w_rise, r_prev;
  logic [IRQ_NUM-1:0] w_edge_mask, w_pend, w_elig, w_clr, r_pend;
  logic               r_nmi_pend, r_nmi_active, w_nmi_pend, w_nmi_elig;
  logic               w_gate, w_ack, w_ack_nmi, w_any, w_latched_elig, w_fast_latched;
  exc_cause_e         w_win, w_fast_win, r_cause, w_cause_nxt;
  irq_state_e         r_state, w_state_nxt;

  assign w_src = {irq_nm_i, irqs_i};

  irq_sync #(
    .WIDTH  (IRQ_NUM + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (w_src),
    .o_q   (w_sync)
  );

  // Map the per-fast-index edge selection onto mip bit positions.
  always_comb begin
    w_edge_mask = '0;
    for (int i = 0; i < IRQ_FAST_NUM; i++) w_edge_mask[CSR_MFIX_BIT[i]] = EDGE_FAST[i];
  end

  // A fresh edge counts as pending in the same cycle it is seen.
  assign w_rise     = w_sync & ~r_prev;
  assign w_pend     = (w_sync[IRQ_NUM-1:0] & ~w_edge_mask)
                    | ((r_pend | w_rise[IRQ_NUM-1:0]) & w_edge_mask);
  assign w_nmi_pend = r_nmi_pend | w_rise[IRQ_NUM];

  assign w_gate     = mstatus_mie_i & ~debug_mode_i;
  assign w_elig     = w_pend & csr_mie_i & {IRQ_NUM{w_gate}};
  assign w_nmi_elig = w_nmi_pend & ~r_nmi_active & ~debug_mode_i;
  assign w_any      = w_nmi_elig | (|w_elig);

  assign w_ack      = irq_ack_i & (r_state == ST_REQ);
  assign w_ack_nmi  = w_ack & (r_cause == EXC_CAUSE_IRQ_NM);

  // Fixed-priority encoder: NMI, MEI, MSI, MTI, then fast0 (highest) .. fast14.
  always_comb begin
    w_fast_win = EXC_CAUSE_NONE;
    for (int i = IRQ_FAST_NUM - 1; i >= 0; i--) begin
      w_fast_win = w_elig[CSR_MFIX_BIT[i]] ? irq_fast_cause(4'(i)) : w_fast_win;
    end
    if (w_nmi_elig)                 w_win = EXC_CAUSE_IRQ_NM;
    else if (w_elig[CSR_MEIX_BIT])  w_win = EXC_CAUSE_IRQ_EXTERNAL_M;
    else if (w_elig[CSR_MSIX_BIT])  w_win = EXC_CAUSE_IRQ_SOFTWARE_M;
    else if (w_elig[CSR_MTIX_BIT])  w_win = EXC_CAUSE_IRQ_TIMER_M;
    else                            w_win = w_fast_win;
  end

  // Decode the latched cause: its current eligibility and the edge bit an ack clears.
  always_comb begin
    w_clr          = '0;
    w_fast_latched = 1'b0;
    for (int i = 0; i < IRQ_FAST_NUM; i++) begin
      if (r_cause == irq_fast_cause(4'(i))) begin
        w_clr[CSR_MFIX_BIT[i]] = w_ack;
        w_fast_latched         = w_elig[CSR_MFIX_BIT[i]];
      end else begin
        w_clr[CSR_MFIX_BIT[i]] = 1'b0;
      end
    end
    case (r_cause)
      EXC_CAUSE_IRQ_NM:         w_latched_elig = 1'b1;
      EXC_CAUSE_IRQ_EXTERNAL_M: w_latched_elig = w_elig[CSR_MEIX_BIT];
      EXC_CAUSE_IRQ_SOFTWARE_M: w_latched_elig = w_elig[CSR_MSIX_BIT];
      EXC_CAUSE_IRQ_TIMER_M:    w_latched_elig = w_elig[CSR_MTIX_BIT];
      default:                  w_latched_elig = w_fast_latched;
    endcase
  end

  // FSM next state; the cause is captured only on IDLE->REQ and frozen in REQ.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_REQ;
          w_cause_nxt = w_win;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_ack || !w_latched_elig) w_state_nxt = ST_IDLE;
        else                          w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and latched cause registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cause <= EXC_CAUSE_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Edge-pending and NMI-nesting state; a new edge wins over a clearing ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prev       <= '0;
      r_pend       <= '0;
      r_nmi_pend   <= 1'b0;
      r_nmi_active <= 1'b0;
    end else begin
      r_prev     <= w_sync;
      r_pend     <= ((r_pend & ~w_clr) | w_rise[IRQ_NUM-1:0]) & w_edge_mask;
      r_nmi_pend <= (r_nmi_pend & ~w_ack_nmi) | w_rise[IRQ_NUM];
      if (w_ack_nmi)       r_nmi_active <= 1'b1;
      else if (nmi_done_i) r_nmi_active <= 1'b0;
      else                 r_nmi_active <= r_nmi_active;
    end
  end

  assign irq_req_o   = (r_state == ST_REQ);
  assign irq_cause_o = r_cause;
  assign csr_mip_o   = w_pend;

endmodule
